// File: rtl/full_adder_unit.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_unit
//  Description : Parameterizable ripple-carry adder built as a chain of 1-bit
//                full-adder cells. Computes {cout,s} = a + b + cin and flags
//                two's-complement overflow. Outputs are either registered
//                (REG_OUT=1, 1-cycle latency) or purely combinational
//                (REG_OUT=0).
//
//  Parameters  : WIDTH   - operand/sum width in bits (1..64)
//                REG_OUT - 1: registered outputs, 0: combinational outputs
//
//  Ports       : clk       in   clock, rising edge
//                rst       in   synchronous active-high reset
//                in_valid  in   a/b/cin valid this cycle
//                a, b      in   WIDTH-bit operands
//                cin       in   carry-in
//                s         out  WIDTH-bit sum, (a+b+cin) mod 2^WIDTH
//                cout      out  carry out of the MSB
//                ovf       out  signed overflow (carry into MSB ^ carry out)
//                out_valid out  s/cout/ovf qualifier
//
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder_unit #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  // --------------------------------------------------------------------------
  // Ripple-carry chain. c_d[i] is the carry into bit i; c_d[0] is cin and
  // c_d[WIDTH] is the carry out of the MSB.
  // --------------------------------------------------------------------------
  logic [WIDTH:0]   c_d;
  logic [WIDTH-1:0] s_d;
  logic             cout_d;
  logic             ovf_d;

  assign c_d[0] = cin;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      logic w_p;  // propagate
      logic w_g;  // generate
      assign w_p        = a[i] ^ b[i];
      assign w_g        = a[i] & b[i];
      assign s_d[i]     = w_p ^ c_d[i];
      assign c_d[i+1]   = w_g | (c_d[i] & w_p);
    end : g_cell
  endgenerate

  assign cout_d = c_d[WIDTH];
  // For WIDTH=1 this reduces to cout ^ cin, since c_d[0] is cin.
  assign ovf_d  = c_d[WIDTH] ^ c_d[WIDTH-1];

  // --------------------------------------------------------------------------
  // Output stage
  // --------------------------------------------------------------------------
  generate
    if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] s_q;
      logic             cout_q;
      logic             ovf_q;
      logic             valid_q;

      // Result is captured every cycle; out_valid alone says whether it
      // belongs to a real operation. Reset clears everything so no stale
      // valid survives a mid-stream reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          s_q     <= '0;
          cout_q  <= 1'b0;
          ovf_q   <= 1'b0;
          valid_q <= 1'b0;
        end else begin
          s_q     <= s_d;
          cout_q  <= cout_d;
          ovf_q   <= ovf_d;
          valid_q <= in_valid;
        end
      end

      assign s         = s_q;
      assign cout      = cout_q;
      assign ovf       = ovf_q;
      assign out_valid = valid_q;
    end : g_reg
    else begin : g_comb
      // clk has no function here; rst only gates the valid qualifier.
      logic w_unused_clk;
      assign w_unused_clk = clk;

      assign s         = s_d;
      assign cout      = cout_d;
      assign ovf       = ovf_d;
      assign out_valid = in_valid & ~rst;
    end : g_comb
  endgenerate

endmodule : full_adder_unit
`default_nettype wire

// File: tb/tb_full_adder_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_full_adder_unit
//  Description : Self-checking bench for full_adder_unit. Three instances:
//                WIDTH=1/REG_OUT=1, WIDTH=8/REG_OUT=1, WIDTH=4/REG_OUT=0.
//                Expected values come from an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_full_adder_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // WIDTH=1, registered
  logic       v1, cin1, s1, co1, ov1, ovld1;
  logic [0:0] a1, b1, so1;
  // WIDTH=8, registered
  logic       v8, cin8, co8, ov8, ovld8;
  logic [7:0] a8, b8, so8;
  // WIDTH=4, combinational
  logic       v4, cin4, co4, ov4, ovld4;
  logic [3:0] a4, b4, so4;

  assign s1 = so1[0];

  full_adder_unit #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .cin(cin1),
    .s(so1), .cout(co1), .ovf(ov1), .out_valid(ovld1)
  );

  full_adder_unit #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .cin(cin8),
    .s(so8), .cout(co8), .ovf(ov8), .out_valid(ovld8)
  );

  full_adder_unit #(.WIDTH(4), .REG_OUT(1'b0)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .cin(cin4),
    .s(so4), .cout(co4), .ovf(ov4), .out_valid(ovld4)
  );

  // Reference model: plain integer arithmetic. Returns {ovf, cout, s[63:0]}.
  // Signed overflow = true signed sum falls outside the WIDTH-bit range.
  function automatic logic [65:0] model(input int w, input longint ua,
                                        input longint ub, input bit ci);
    longint sum, sa, sb, ss, half, full;
    logic [65:0] r;
    full = longint'(1) <<< w;
    half = longint'(1) <<< (w - 1);
    sum  = ua + ub + longint'(ci);
    sa   = (ua >= half) ? ua - full : ua;
    sb   = (ub >= half) ? ub - full : ub;
    ss   = sa + sb + longint'(ci);
    r        = '0;
    r[63:0]  = sum % full;
    r[64]    = (sum >= full);
    r[65]    = (ss > half - 1) || (ss < -half);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [65:0] m;
    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; v1 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; v8 = 1'b1;
    a4 = 4'h9; b4 = 4'h8; cin4 = 1'b1; v4 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      if ({ovld1, co1, ov1, s1} !== 4'b0000) begin
        n_err++; $display("FAIL reset_w1 cyc%0d: got %b expected 0000", k, {ovld1, co1, ov1, s1});
      end
      n_vec++;
      if ({ovld8, co8, ov8, so8} !== 11'h0) begin
        n_err++; $display("FAIL reset_w8 cyc%0d: got %h expected 000", k, {ovld8, co8, ov8, so8});
      end
      n_vec++;
      if (ovld4 !== 1'b0) begin
        n_err++; $display("FAIL reset_comb_valid: got %b expected 0", ovld4);
      end
      n_vec++;
    end
    rst = 1'b0;
    #1;
    if (ovld4 !== 1'b1) begin
      n_err++; $display("FAIL comb_valid_after_reset: got %b expected 1", ovld4);
    end
    n_vec++;
    tick();
    m = model(1, 1, 1, 1'b1);
    if ({ovld1, co1, ov1, s1} !== {1'b1, m[64], m[65], m[0]}) begin
      n_err++; $display("FAIL post_reset_w1: got %b expected %b", {ovld1, co1, ov1, s1}, {1'b1, m[64], m[65], m[0]});
    end
    n_vec++;
  endtask

  task automatic test_exhaustive_w1();
    logic [65:0] m;
    logic [2:0]  abc;
    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      {a1[0], b1[0], cin1} = abc;
      v1 = 1'b1;
      m = model(1, longint'(abc[2]), longint'(abc[1]), abc[0]);
      tick();
      if ({ovld1, co1, s1, ov1} !== {1'b1, m[64], m[0], m[65]}) begin
        n_err++; $display("FAIL exhaustive_w1 abc=%b: got v/co/s/ov=%b expected %b", abc, {ovld1, co1, s1, ov1}, {1'b1, m[64], m[0], m[65]});
      end
      n_vec++;
    end
  endtask

  task automatic test_carry_chain();
    // FF+00+1 -> 00, cout=1, ovf=0 ; 7F+01+0 -> 80, cout=0, ovf=1
    a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1; v8 = 1'b1;
    tick();
    if ({ovld8, co8, ov8, so8} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
      n_err++; $display("FAIL carry_ff: got %h expected %h", {ovld8, co8, ov8, so8}, {1'b1, 1'b1, 1'b0, 8'h00});
    end
    n_vec++;
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
    tick();
    if ({ovld8, co8, ov8, so8} !== {1'b1, 1'b0, 1'b1, 8'h80}) begin
      n_err++; $display("FAIL carry_7f: got %h expected %h", {ovld8, co8, ov8, so8}, {1'b1, 1'b0, 1'b1, 8'h80});
    end
    n_vec++;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  ta[3], tb[3];
    logic        tc[3];
    logic [10:0] exp3[3];
    ta = '{8'h10, 8'hF0, 8'h80};
    tb = '{8'h20, 8'h20, 8'h80};
    tc = '{1'b0, 1'b1, 1'b0};
    // valid, cout, ovf, s
    exp3 = '{{1'b1, 1'b0, 1'b0, 8'h30}, {1'b1, 1'b1, 1'b0, 8'h11}, {1'b1, 1'b1, 1'b1, 8'h00}};
    for (int i = 0; i < 3; i++) begin
      a8 = ta[i]; b8 = tb[i]; cin8 = tc[i]; v8 = 1'b1;
      tick();
      if ({ovld8, co8, ov8, so8} !== exp3[i]) begin
        n_err++; $display("FAIL back_to_back op%0d: got %h expected %h", i, {ovld8, co8, ov8, so8}, exp3[i]);
      end
      n_vec++;
    end
  endtask

  task automatic test_valid_gap();
    logic [65:0] m0, m2;
    a8 = 8'h3C; b8 = 8'h5A; cin8 = 1'b1; v8 = 1'b1;
    m0 = model(8, 64'h3C, 64'h5A, 1'b1);
    tick();
    if ({ovld8, co8, ov8, so8} !== {1'b1, m0[64], m0[65], m0[7:0]}) begin
      n_err++; $display("FAIL gap_before: got %h expected %h", {ovld8, co8, ov8, so8}, {1'b1, m0[64], m0[65], m0[7:0]});
    end
    n_vec++;
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; v8 = 1'b0;
    tick();
    if (ovld8 !== 1'b0) begin
      n_err++; $display("FAIL gap_valid: got %b expected 0", ovld8);
    end
    n_vec++;
    a8 = 8'hC8; b8 = 8'h9B; cin8 = 1'b0; v8 = 1'b1;
    m2 = model(8, 64'hC8, 64'h9B, 1'b0);
    tick();
    if ({ovld8, co8, ov8, so8} !== {1'b1, m2[64], m2[65], m2[7:0]}) begin
      n_err++; $display("FAIL gap_after: got %h expected %h", {ovld8, co8, ov8, so8}, {1'b1, m2[64], m2[65], m2[7:0]});
    end
    n_vec++;
  endtask

  task automatic test_midstream_reset();
    // Operation launched together with reset must not appear; no stale valid.
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; v8 = 1'b1;
    rst = 1'b1;
    tick();
    if ({ovld8, co8, ov8, so8} !== 11'h0) begin
      n_err++; $display("FAIL midreset_drop: got %h expected 000", {ovld8, co8, ov8, so8});
    end
    n_vec++;
    rst = 1'b0; v8 = 1'b0;
    tick();
    if (ovld8 !== 1'b0) begin
      n_err++; $display("FAIL midreset_stale_valid: got %b expected 0", ovld8);
    end
    n_vec++;
  endtask

  task automatic test_comb_w4();
    logic [65:0] m;
    a4 = 4'h9; b4 = 4'h8; cin4 = 1'b1; v4 = 1'b1;
    #1;
    if ({ovld4, co4, ov4, so4} !== {1'b1, 1'b1, 1'b1, 4'h2}) begin
      n_err++; $display("FAIL comb_w4_directed: got %h expected %h", {ovld4, co4, ov4, so4}, {1'b1, 1'b1, 1'b1, 4'h2});
    end
    n_vec++;
    for (int i = 0; i < 40; i++) begin
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom); v4 = 1'($urandom);
      m = model(4, longint'(a4), longint'(b4), cin4);
      #2;
      if ({ovld4, co4, ov4, so4} !== {v4, m[64], m[65], m[3:0]}) begin
        n_err++; $display("FAIL comb_w4_rand a=%h b=%h c=%b: got %h expected %h", a4, b4, cin4, {ovld4, co4, ov4, so4}, {v4, m[64], m[65], m[3:0]});
      end
      n_vec++;
    end
  endtask

  task automatic test_random_w8();
    logic [65:0] m;
    logic        vexp;
    for (int i = 0; i < 200; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      v8 = ($urandom_range(0, 3) != 0);
      m = model(8, longint'(a8), longint'(b8), cin8);
      vexp = v8;
      tick();
      if ({ovld8, co8, ov8, so8} !== {vexp, m[64], m[65], m[7:0]}) begin
        n_err++; $display("FAIL rand_w8 #%0d: got %h expected %h", i, {ovld8, co8, ov8, so8}, {vexp, m[64], m[65], m[7:0]});
      end
      n_vec++;
    end
  endtask

  initial begin
    rst = 1'b1;
    v1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    v8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    v4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    #1;
    test_reset();
    test_exhaustive_w1();
    test_carry_chain();
    test_back_to_back();
    test_valid_gap();
    test_midstream_reset();
    test_comb_w4();
    test_random_w8();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_full_adder_unit
`default_nettype wire
